mem_arbiter: RTL and testbench

- Shares one main-memory block port between the instruction cache and the data cache of the 5-stage pipelined CPU.
- Each cache raises a block request on a miss (reads for the I-cache; reads or write-backs for the D-cache).
- The arbiter grants one requester at a time, forwards its command to memory, and returns the completion and read data.
- It drives the per-cache busy-wait lines that stall the pipeline.

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and main-memory block-port signals shared by mem_arbiter.
// The slave modport is the arbiter's view; master is the environment (caches + memory).
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 128
);
   logic                  I_READ;
   logic [ADDR_WIDTH-1:0] I_ADDR;
   logic [DATA_WIDTH-1:0] I_READDATA;
   logic                  I_BUSYWAIT;

   logic                  D_READ;
   logic                  D_WRITE;
   logic [ADDR_WIDTH-1:0] D_ADDR;
   logic [DATA_WIDTH-1:0] D_WRITEDATA;
   logic [DATA_WIDTH-1:0] D_READDATA;
   logic                  D_BUSYWAIT;

   logic                  MEM_READ;
   logic                  MEM_WRITE;
   logic [ADDR_WIDTH-1:0] MEM_ADDR;
   logic [DATA_WIDTH-1:0] MEM_WRITEDATA;
   logic [DATA_WIDTH-1:0] MEM_READDATA;
   logic                  MEM_BUSYWAIT;

   // Handshake: a cache holds its request and address until it sees its busywait low
   // for one cycle; memory raises MEM_BUSYWAIT with the command and drops it in the
   // completion cycle, when MEM_READDATA is valid.
   modport master (
      output I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
             MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
   );

   modport slave (
      input  I_READ, I_ADDR, D_READ, D_WRITE, D_ADDR, D_WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
             MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache onto one main-memory block port.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin on contention (default: D over I).
module mem_arbiter #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 128
) (
   input  logic        CLK,
   input  logic        RESET,
   mem_arbiter_if.slave bus,
   output logic [2:0]  STATE
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT_I = 3'd1,
      GRANT_D = 3'd2,
      DONE_I  = 3'd3,
      DONE_D  = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic                  req_i, req_d;
   logic                  grant_i, grant_d;
   logic                  complete;
   logic                  mem_read_q, mem_write_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic last_grant_q;  // 0 = I was granted last, 1 = D
`endif

   assign req_i    = bus.I_READ;
   assign req_d    = bus.D_READ | bus.D_WRITE;
   assign complete = ((state_q == GRANT_I) || (state_q == GRANT_D)) && !bus.MEM_BUSYWAIT;

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      case (state_q)
         IDLE: begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            if (req_i && req_d) begin
               if (last_grant_q) grant_i = 1'b1;
               else              grant_d = 1'b1;
            end else if (req_d) grant_d = 1'b1;
            else if (req_i)     grant_i = 1'b1;
`else
            if (req_d)      grant_d = 1'b1;
            else if (req_i) grant_i = 1'b1;
`endif
            if (grant_d)      state_d = GRANT_D;
            else if (grant_i) state_d = GRANT_I;
         end
         GRANT_I: if (!bus.MEM_BUSYWAIT) state_d = DONE_I;
         GRANT_D: if (!bus.MEM_BUSYWAIT) state_d = DONE_D;
         DONE_I:  state_d = IDLE;
         DONE_D:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Command is captured once at the granting edge and held; requester changes are ignored.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else if (grant_d) begin
         mem_addr_q  <= bus.D_ADDR;
         mem_wdata_q <= bus.D_WRITEDATA;
         mem_write_q <= bus.D_WRITE;
         mem_read_q  <= ~bus.D_WRITE;
      end else if (grant_i) begin
         mem_addr_q  <= bus.I_ADDR;
         mem_read_q  <= 1'b1;
         mem_write_q <= 1'b0;
      end else if (complete) begin
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         if (mem_read_q && (state_q == GRANT_I)) i_rdata_q <= bus.MEM_READDATA;
         if (mem_read_q && (state_q == GRANT_D)) d_rdata_q <= bus.MEM_READDATA;
      end
   end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   always_ff @(posedge CLK) begin
      if (RESET)        last_grant_q <= 1'b0;
      else if (grant_d) last_grant_q <= 1'b1;
      else if (grant_i) last_grant_q <= 1'b0;
   end
`endif

   assign bus.MEM_READ      = mem_read_q;
   assign bus.MEM_WRITE     = mem_write_q;
   assign bus.MEM_ADDR      = mem_addr_q;
   assign bus.MEM_WRITEDATA = mem_wdata_q;
   assign bus.I_READDATA    = i_rdata_q;
   assign bus.D_READDATA    = d_rdata_q;

   // Busywait depends only on the request and registered state, never on memory inputs.
   assign bus.I_BUSYWAIT = req_i & (state_q != DONE_I);
   assign bus.D_BUSYWAIT = req_d & (state_q != DONE_D);

   assign STATE = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_mem_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam logic [2:0] S_IDLE = 3'd0, S_GI = 3'd1, S_GD = 3'd2, S_DI = 3'd3, S_DD = 3'd4;
   localparam logic [DW-1:0] WD = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

   typedef struct {
      logic          ir, dr, dw;
      logic [AW-1:0] ia, da;
      logic [2:0]    st;
      logic          mr, mw;
      logic [AW-1:0] ma;
      logic          ibw, dbw;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [2:0] state;
   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         mem_cnt = 0;
   int         lat = 4;
   vec_t       vecs[$];
   logic [DW-1:0] exp_q[$];
   logic [2:0] got[$];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
   endfunction

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .CLK  (CLK),
      .RESET(RESET),
      .bus  (bus.slave),
      .STATE(state)
   );

   // clock / memory model
   always #5 CLK = ~CLK;

   assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (mem_cnt < lat);
   assign bus.MEM_READDATA = pat(bus.MEM_ADDR);

   always @(posedge CLK) begin
      if (!(bus.MEM_READ | bus.MEM_WRITE)) mem_cnt <= 0;
      else if (bus.MEM_BUSYWAIT)           mem_cnt <= mem_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // driver tasks
   task automatic drive(input logic ir, input logic dr, input logic dw,
                        input logic [AW-1:0] ia, input logic [AW-1:0] da);
      bus.I_READ  = ir;
      bus.D_READ  = dr;
      bus.D_WRITE = dw;
      bus.I_ADDR  = ia;
      bus.D_ADDR  = da;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add(input logic ir, input logic dr, input logic dw,
                      input logic [AW-1:0] ia, input logic [AW-1:0] da,
                      input logic [2:0] st, input logic mr, input logic mw,
                      input logic [AW-1:0] ma, input logic ibw, input logic dbw);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da;
      v.st = st; v.mr = mr; v.mw = mw; v.ma = ma; v.ibw = ibw; v.dbw = dbw;
      vecs.push_back(v);
   endtask

   // Returns at the falling edge of the cycle in which the selected busywait is low.
   task automatic wait_done(input bit is_d, input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (!(is_d ? bus.D_BUSYWAIT : bus.I_BUSYWAIT)) begin
            seen = 1'b1;
            break;
         end
         @(posedge CLK);
         #1;
      end
      check({name, "_done_seen"}, {255'd0, seen}, 256'd1);
   endtask

   initial begin
      logic [2:0] prev;
      logic [2:0] exp_st;

      // clock/reset block
      RESET = 1'b1;
      bus.D_WRITEDATA = WD;
      drive(0, 0, 0, '0, '0);
      step();
      step();
      check("reset_ctrl", {state, bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR}, '0);
      check("reset_wdata", bus.MEM_WRITEDATA, '0);
      check("reset_i_rdata", bus.I_READDATA, '0);
      check("reset_d_rdata", bus.D_READDATA, '0);
      check("reset_busywait", {bus.I_BUSYWAIT, bus.D_BUSYWAIT}, '0);
      RESET = 1'b0;

      // I read, memory latency 4: grant c1..c5, DONE_I in c6
      add(1, 0, 0, 28'h10, 28'h0, S_IDLE, 0, 0, 28'h0, 1, 0);
      for (int k = 0; k < 5; k++) add(1, 0, 0, 28'h10, 28'h0, S_GI, 1, 0, 28'h10, 1, 0);
      add(1, 0, 0, 28'h10, 28'h0, S_DI, 0, 0, 28'h10, 0, 0);
      add(0, 0, 0, 28'h10, 28'h0, S_IDLE, 0, 0, 28'h10, 0, 0);
      // I read and D write together: D served first, I after DONE_D + IDLE
      add(1, 0, 1, 28'h10, 28'h20, S_IDLE, 0, 0, 28'h10, 1, 1);
      for (int k = 0; k < 5; k++) add(1, 0, 1, 28'h10, 28'h20, S_GD, 0, 1, 28'h20, 1, 1);
      add(1, 0, 1, 28'h10, 28'h20, S_DD, 0, 0, 28'h20, 1, 0);
      add(1, 0, 0, 28'h10, 28'h20, S_IDLE, 0, 0, 28'h20, 1, 0);
      for (int k = 0; k < 5; k++) add(1, 0, 0, 28'h10, 28'h20, S_GI, 1, 0, 28'h10, 1, 0);
      add(1, 0, 0, 28'h10, 28'h20, S_DI, 0, 0, 28'h10, 0, 0);
      add(0, 0, 0, 28'h10, 28'h20, S_IDLE, 0, 0, 28'h10, 0, 0);

      foreach (vecs[k]) begin
         drive(vecs[k].ir, vecs[k].dr, vecs[k].dw, vecs[k].ia, vecs[k].da);
         @(negedge CLK);
         check($sformatf("vec%0d", k),
               {state, bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR, bus.I_BUSYWAIT, bus.D_BUSYWAIT},
               {vecs[k].st, vecs[k].mr, vecs[k].mw, vecs[k].ma, vecs[k].ibw, vecs[k].dbw});
         @(posedge CLK);
         #1;
      end
      check("i_rdata_after_table", bus.I_READDATA, pat(28'h10));
      check("wdata_after_table", bus.MEM_WRITEDATA, WD);

      // reset while GRANT_I is waiting on memory
      drive(1, 0, 0, 28'h50, '0);
      step();
      step();
      @(negedge CLK);
      check("pre_reset_in_grant", {state, bus.MEM_BUSYWAIT}, {S_GI, 1'b1});
      RESET = 1'b1;
      step();
      check("reset_abort_ctrl", {state, bus.MEM_READ, bus.I_BUSYWAIT}, {S_IDLE, 1'b0, 1'b1});
      check("reset_abort_i_rdata", bus.I_READDATA, '0);
      RESET = 1'b0;
      exp_q.push_back(pat(28'h50));
      wait_done(0, "i_after_reset");
      check("i_after_reset_rdata", bus.I_READDATA, exp_q.pop_front());
      step();
      drive(0, 0, 0, '0, '0);

      // D read with D_ADDR changed two cycles into the grant
      drive(0, 1, 0, '0, 28'h44);
      step();
      step();
      step();
      drive(0, 1, 0, '0, 28'h30);
      exp_q.push_back(pat(28'h44));
      @(negedge CLK);
      check("addr_hold_mid", {state, bus.MEM_READ, bus.MEM_ADDR}, {S_GD, 1'b1, 28'h44});
      wait_done(1, "d_read");
      check("addr_hold_done", bus.MEM_ADDR, 28'h44);
      check("d_read_rdata", bus.D_READDATA, exp_q.pop_front());
      step();
      drive(0, 0, 0, '0, '0);

      // D_READ and D_WRITE together: write wins, D_READDATA untouched
      drive(0, 1, 1, '0, 28'h60);
      step();
      check("rw_cmd", {state, bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR}, {S_GD, 1'b0, 1'b1, 28'h60});
      wait_done(1, "d_rw");
      check("rw_d_rdata_kept", bus.D_READDATA, pat(28'h44));
      step();
      drive(0, 0, 0, '0, '0);

      // both requesters held across four grants, starting from reset
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      drive(1, 1, 0, 28'h70, 28'h80);
      prev = S_IDLE;
      for (int k = 0; k < 60 && got.size() < 4; k++) begin
         @(negedge CLK);
         if ((state == S_GI || state == S_GD) && !(prev == S_GI || prev == S_GD)) got.push_back(state);
         prev = state;
         @(posedge CLK);
         #1;
      end
      check("grant_count", got.size(), 4);
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         exp_st = (k % 2 == 0) ? S_GD : S_GI;
`else
         exp_st = S_GD;
`endif
         if (k < got.size()) check($sformatf("grant_order%0d", k), got[k], exp_st);
      end
      drive(0, 0, 0, '0, '0);
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
